// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus for fetch_unit.
// Handshake: the fetch unit raises instReq with instReqAddr and holds both
// stable until the memory answers with a one-cycle instRdy strobe carrying
// instData; instReq is the valid, instRdy acts as ready+response, and only
// one request is ever outstanding.
interface fetch_unit_if;
  logic        instReq;
  logic [31:0] instReqAddr;
  logic        instRdy;
  logic [31:0] instData;

  modport master (output instReq, output instReqAddr, input instRdy, input instData);
  modport slave  (input instReq, input instReqAddr, output instRdy, output instData);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a small
// {pc,inst} queue that drains to the decoder one entry per unstalled cycle.
// Optional macro IF_JAL_PREDICT_EN: follow JAL targets when computing the
// next fetch PC instead of always stepping by 4.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  fetch_unit_if.master                       mem,
  input  logic                               stall,
  input  logic                               jumpEn,
  input  logic [31:0]                        jumpAddr,
  output logic                               DecEn,
  output logic [31:0]                        instPC,
  output logic [31:0]                        inst,
  output logic [1:0]                         dbg_state,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   dbg_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           req_q, req_d;
  logic [31:0]    req_addr_q, req_addr_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           dec_en_q, dec_en_d;
  logic [31:0]    inst_pc_q, inst_pc_d;
  logic [31:0]    inst_q, inst_d;

  logic [31:0]    fifo_pc_q   [QUEUE_DEPTH];
  logic [31:0]    fifo_inst_q [QUEUE_DEPTH];

  logic           push;
  logic           pop;
  logic [31:0]    seq_pc;

`ifdef IF_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_imm;

  // JAL target prediction: decode the J-immediate of the returning word
  always_comb begin
    is_jal  = (mem.instData[6:0] == 7'b1101111);
    jal_imm = {{11{mem.instData[31]}}, mem.instData[31], mem.instData[19:12],
               mem.instData[20], mem.instData[30:21], 1'b0};
    seq_pc  = is_jal ? (req_addr_q + jal_imm) : (req_addr_q + 32'd4);
  end
`else
  // Sequential next fetch address (wraps modulo 2^32)
  always_comb begin
    seq_pc = req_addr_q + 32'd4;
  end
`endif

  // Fetch FSM next-state: issue, wait for response, or swallow a stale one
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!jumpEn && (count_q < FULL)) begin
          req_addr_d = fetch_pc_q;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (jumpEn) begin
          state_d = mem.instRdy ? ST_IDLE : ST_DISCARD;
        end else if (mem.instRdy) begin
          push       = 1'b1;
          fetch_pc_d = seq_pc;
          state_d    = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (mem.instRdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A redirect always wins over sequential/predicted advance
    if (jumpEn) begin
      fetch_pc_d = jumpAddr;
    end
    req_d = (state_d == ST_WAIT) || (state_d == ST_DISCARD);
  end

  // Queue bookkeeping and registered decoder outputs
  always_comb begin
    pop       = !stall && (count_q != '0) && !jumpEn;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dec_en_d  = 1'b0;
    inst_pc_d = inst_pc_q;
    inst_d    = inst_q;
    if (jumpEn) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        dec_en_d  = 1'b1;
        inst_pc_d = fifo_pc_q[rd_ptr_q];
        inst_d    = fifo_inst_q[rd_ptr_q];
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]   <= req_addr_q;
      fifo_inst_q[wr_ptr_q] <= mem.instData;
    end
  end

  // All control state, asynchronously cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      req_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dec_en_q   <= 1'b0;
      inst_pc_q  <= '0;
      inst_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dec_en_q   <= dec_en_d;
      inst_pc_q  <= inst_pc_d;
      inst_q     <= inst_d;
    end
  end

  assign mem.instReq     = req_q;
  assign mem.instReqAddr = req_addr_q;
  assign DecEn           = dec_en_q;
  assign instPC          = inst_pc_q;
  assign inst            = inst_q;
  assign dbg_state       = state_q;
  assign dbg_count       = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized phase, with a
// {pc,inst} expected queue filled when the memory answers and drained when
// the decoder outputs fire; request addresses are predicted by a small model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          QD       = 4;
  localparam int          W        = 64;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jumpEn;
  logic [31:0] jumpAddr;
  logic        DecEn;
  logic [31:0] instPC;
  logic [31:0] inst;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_count;

  fetch_unit_if mem_bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(QD)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem_bus),
    .stall    (stall),
    .jumpEn   (jumpEn),
    .jumpAddr (jumpAddr),
    .DecEn    (DecEn),
    .instPC   (instPC),
    .inst     (inst),
    .dbg_state(dbg_state),
    .dbg_count(dbg_count)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_err    = 0;
  logic         prev_req;
  logic [31:0]  prev_addr;
  logic         tb_discard;
  logic [31:0]  exp_next;
  int           push_cnt;
  logic         mem_auto;
  int           mem_lat;
  int           wait_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  function automatic logic [31:0] next_of(input logic [31:0] pc, input logic [31:0] d);
`ifdef IF_JAL_PREDICT_EN
    if (d[6:0] == 7'b1101111)
      return pc + {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
`endif
    return pc + 32'd4;
  endfunction

  // Called at each falling edge: check outputs, update model, run memory
  task automatic monitor();
    logic [W-1:0] e;
    if (!rst) begin
      exp_q.delete();
      prev_req   = 1'b0;
      prev_addr  = RESET_PC;
      tb_discard = 1'b0;
      exp_next   = RESET_PC;
      wait_cnt   = 0;
      if (mem_auto) mem_bus.instRdy = 1'b0;
    end else begin
      if (DecEn) begin
        if (exp_q.size() == 0) begin
          chk("dec_unexpected", instPC, 32'hDEADBEEF);
        end else begin
          e = exp_q.pop_front();
          chk("dec_pc", instPC, e[63:32]);
          chk("dec_inst", inst, e[31:0]);
        end
      end
      if (jumpEn) exp_q.delete();
      if (prev_req && mem_bus.instRdy) begin
        if (!jumpEn && !tb_discard) begin
          exp_q.push_back({prev_addr, mem_bus.instData});
          exp_next = next_of(prev_addr, mem_bus.instData);
          push_cnt++;
        end
        tb_discard = 1'b0;
      end else if (prev_req && jumpEn) begin
        tb_discard = 1'b1;
      end
      if (jumpEn) exp_next = jumpAddr;
      if (mem_bus.instReq && !prev_req) chk("req_addr", mem_bus.instReqAddr, exp_next);
      if (mem_bus.instReq && prev_req)  chk("req_hold", mem_bus.instReqAddr, prev_addr);
      prev_req  = mem_bus.instReq;
      prev_addr = mem_bus.instReqAddr;
      if (mem_auto) begin
        if (mem_bus.instRdy) begin
          mem_bus.instRdy = 1'b0;
          wait_cnt = 0;
        end else if (mem_bus.instReq) begin
          if (wait_cnt >= mem_lat) begin
            mem_bus.instRdy  = 1'b1;
            mem_bus.instData = mem_word(mem_bus.instReqAddr);
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_bus.instReq && n < 50) begin
      tick();
      n++;
    end
    if (!mem_bus.instReq) chk("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_rdy(input logic [31:0] d);
    mem_bus.instRdy  = 1'b1;
    mem_bus.instData = d;
    tick();
    mem_bus.instRdy  = 1'b0;
  endtask

  task automatic serve();
    wait_req();
    pulse_rdy(mem_word(mem_bus.instReqAddr));
  endtask

  task automatic redirect(input logic [31:0] a);
    wait_req();
    jumpEn   = 1'b1;
    jumpAddr = a;
    tick();
    jumpEn = 1'b0;
    pulse_rdy(32'h0);
    wait_req();
  endtask

  task automatic do_reset();
    mem_auto        = 1'b0;
    mem_bus.instRdy = 1'b0;
    jumpEn          = 1'b0;
    stall           = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_bus.instReq}, 32'd0);
    chk("rst_dec", {31'd0, DecEn}, 32'd0);
    chk("rst_pc", instPC, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_cnt", {29'd0, dbg_count}, 32'd0);
    chk("rst_addr", mem_bus.instReqAddr, RESET_PC);
    tick();
    tick();
    rst      = 1'b1;
    push_cnt = 0;
  endtask

  initial begin
    rst              = 1'b0;
    stall            = 1'b0;
    jumpEn           = 1'b0;
    jumpAddr         = 32'h0;
    mem_bus.instRdy  = 1'b0;
    mem_bus.instData = 32'h0;
    mem_auto         = 1'b0;
    mem_lat          = 0;
    wait_cnt         = 0;
    push_cnt         = 0;
    prev_req         = 1'b0;
    prev_addr        = RESET_PC;
    tb_discard       = 1'b0;
    exp_next         = RESET_PC;

    // first fetch after reset and minimum latency
    do_reset();
    tick();
    chk("t1_req", {31'd0, mem_bus.instReq}, 32'd1);
    chk("t1_addr", mem_bus.instReqAddr, 32'h0);
    tick();
    tick();
    pulse_rdy(32'h00000013);
    chk("t1_dec_t1", {31'd0, DecEn}, 32'd0);
    tick();
    chk("t1_dec_t2", {31'd0, DecEn}, 32'd1);
    chk("t1_pc", instPC, 32'h0);
    chk("t1_inst", inst, 32'h13);
    wait_req();
    chk("t1_next", mem_bus.instReqAddr, 32'h4);

    // fill under stall, then drain 4 in a row
    do_reset();
    stall    = 1'b1;
    mem_auto = 1'b1;
    mem_lat  = 0;
    repeat (30) tick();
    mem_auto = 1'b0;
    chk("t2_pushes", push_cnt, 32'd4);
    chk("t2_cnt", {29'd0, dbg_count}, 32'd4);
    chk("t2_noreq", {31'd0, mem_bus.instReq}, 32'd0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_dec", {31'd0, DecEn}, 32'd1);
      chk("t2_pc", instPC, 32'(i * 4));
    end
    tick();
    chk("t2_dec_end", {31'd0, DecEn}, 32'd0);

    // redirect while waiting on 0x8, stale response two cycles later
    do_reset();
    serve();
    serve();
    wait_req();
    chk("t3_wait8", mem_bus.instReqAddr, 32'h8);
    jumpEn   = 1'b1;
    jumpAddr = 32'h100;
    tick();
    jumpEn = 1'b0;
    tick();
    pulse_rdy(mem_word(32'h8));
    chk("t3_cnt", {29'd0, dbg_count}, 32'd0);
    wait_req();
    chk("t3_next", mem_bus.instReqAddr, 32'h100);

    // redirect coincident with response
    do_reset();
    stall = 1'b1;
    serve();
    serve();
    wait_req();
    chk("t4_cnt_before", {29'd0, dbg_count}, 32'd2);
    mem_bus.instRdy  = 1'b1;
    mem_bus.instData = mem_word(32'h8);
    jumpEn           = 1'b1;
    jumpAddr         = 32'h200;
    stall            = 1'b0;
    tick();
    mem_bus.instRdy = 1'b0;
    jumpEn          = 1'b0;
    chk("t4_dec", {31'd0, DecEn}, 32'd0);
    chk("t4_cnt", {29'd0, dbg_count}, 32'd0);
    chk("t4_idle", {31'd0, mem_bus.instReq}, 32'd0);
    tick();
    chk("t4_req", {31'd0, mem_bus.instReq}, 32'd1);
    chk("t4_addr", mem_bus.instReqAddr, 32'h200);

    // JAL word at 0x20, then PC wrap at the top of memory
    do_reset();
    redirect(32'h20);
    chk("t5_at20", mem_bus.instReqAddr, 32'h20);
    pulse_rdy(32'h0100006F);
    wait_req();
`ifdef IF_JAL_PREDICT_EN
    chk("t5_jal_next", mem_bus.instReqAddr, 32'h30);
`else
    chk("t5_jal_next", mem_bus.instReqAddr, 32'h24);
`endif
    redirect(32'hFFFFFFFC);
    serve();
    wait_req();
    chk("t5_wrap", mem_bus.instReqAddr, 32'h0);
    repeat (4) tick();

    // asynchronous reset mid-WAIT with 3 queued entries
    do_reset();
    stall = 1'b1;
    serve();
    serve();
    serve();
    wait_req();
    chk("t6_cnt3", {29'd0, dbg_count}, 32'd3);
    #3 rst = 1'b0;
    #1;
    chk("t6_req0", {31'd0, mem_bus.instReq}, 32'd0);
    chk("t6_dec0", {31'd0, DecEn}, 32'd0);
    chk("t6_cnt0", {29'd0, dbg_count}, 32'd0);
    mem_bus.instRdy  = 1'b1;
    mem_bus.instData = 32'hCAFE0013;
    tick();
    tick();
    mem_bus.instRdy = 1'b0;
    tick();
    rst   = 1'b1;
    stall = 1'b0;
    wait_req();
    chk("t6_first", mem_bus.instReqAddr, RESET_PC);
    serve();
    repeat (4) tick();
    chk("t6_cnt_after", {29'd0, dbg_count}, 32'd0);

    // randomized traffic
    do_reset();
    mem_auto = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) mem_lat = $urandom_range(0, 3);
      stall    = ($urandom_range(0, 3) == 0);
      jumpEn   = ($urandom_range(0, 24) == 0);
      jumpAddr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      tick();
    end
    jumpEn = 1'b0;
    stall  = 1'b0;
    repeat (20) tick();
    mem_auto        = 1'b0;
    mem_bus.instRdy = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, giving the first fetch address after reset.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, giving the instruction-queue entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port instReq  output  1  instruction-memory request valid.
REQ-006 SHALL have port instReqAddr  output  32  request byte address, word aligned.
REQ-007 SHALL have port instRdy  input  1  one-cycle memory response strobe.
REQ-008 SHALL have port instData  input  32  response word, valid while instRdy=1.
REQ-009 SHALL have port stall  input  1  downstream cannot accept an instruction this cycle.
REQ-010 SHALL have port jumpEn  input  1  one-cycle redirect or flush request.
REQ-011 SHALL have port jumpAddr  input  32  redirect target, valid while jumpEn=1.
REQ-012 SHALL have port DecEn  output  1  instPC/inst valid for the decoder this cycle.
REQ-013 SHALL have port instPC  output  32  PC of the delivered instruction.
REQ-014 SHALL have port inst  output  32  delivered instruction word.

Function
REQ-015 SHALL hold fetchPC, a request-address register reqAddr, a QUEUE_DEPTH-entry FIFO of {pc,inst} pairs, and an occupancy count ranging 0..QUEUE_DEPTH.
REQ-016 SHALL implement the fetch FSM with states IDLE, WAIT and DISCARD, and SHALL allow at most one memory request outstanding.
REQ-017 In IDLE with count<QUEUE_DEPTH and jumpEn=0, the FSM SHALL latch reqAddr<=fetchPC and go to WAIT; otherwise it SHALL remain in IDLE.
REQ-018 instReq SHALL be 1 exactly in WAIT and DISCARD, and instReqAddr SHALL equal reqAddr, held stable until instRdy.
REQ-019 In WAIT on instRdy=1 with jumpEn=0, the FSM SHALL push {reqAddr,instData}, set fetchPC<=reqAddr+4, and go to IDLE.
REQ-020 In WAIT on jumpEn=1, the FSM SHALL set fetchPC<=jumpAddr, then go to IDLE if instRdy=1 (data dropped) or to DISCARD if instRdy=0.
REQ-021 In DISCARD on instRdy=1, the FSM SHALL drop instData and go to IDLE; jumpEn in DISCARD SHALL reload fetchPC and the FSM SHALL stay in DISCARD.
REQ-022 Each cycle with stall=0, count>0 and jumpEn=0, the unit SHALL pop the head entry and register DecEn<=1, instPC<=pc and inst<=inst; otherwise it SHALL register DecEn<=0, with instPC/inst holding their values.
REQ-023 A simultaneous push and pop SHALL leave count unchanged; a push SHALL never occur at count=QUEUE_DEPTH, guaranteed by REQ-017.
REQ-024 jumpEn SHALL clear the FIFO (count<=0, pointers reset) that edge, and DecEn SHALL be 0 in the following cycle.
REQ-025 Minimum latency SHALL be: instRdy in cycle t into an empty queue gives DecEn=1 in cycle t+2; no bypass path.
REQ-026 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFFFFFC+4 SHALL wrap to 0.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, fetchPC=RESET_PC, reqAddr=RESET_PC, count=0, FIFO pointers 0, instReq=0, DecEn=0, instPC=0 and inst=0, regardless of the clock.
REQ-028 A response arriving for a request cut off by reset SHALL be ignored; the first request after release SHALL be to RESET_PC.

Configuration
REQ-029 With macro IF_JAL_PREDICT_EN defined, a pushed word with instData[6:0]=7'b1101111 SHALL set fetchPC<=reqAddr+sign-extended J-immediate instead of reqAddr+4; jumpEn SHALL still take priority.
REQ-030 Without IF_JAL_PREDICT_EN, fetchPC SHALL always advance by 4 and no immediate logic SHALL be synthesized.

Verification
REQ-031 Reset release with RESET_PC=0, instRdy 3 cycles later with 32'h00000013 -> instReq/instReqAddr=0 first cycle; DecEn=1, instPC=0, inst=32'h13 two cycles after instRdy; next request addr 32'h4.
REQ-032 stall=1, memory responding every request -> exactly 4 pushes then instReq stays 0; stall released -> DecEn on 4 consecutive cycles with instPC 0,4,8,C.
REQ-033 jumpEn with jumpAddr=32'h100 while WAIT on 32'h8, instRdy 2 cycles later -> no DecEn for PC 8, queue empty, next instReqAddr=32'h100.
REQ-034 jumpEn coincident with instRdy -> data dropped, FSM IDLE, next request to jumpAddr, DecEn=0 next cycle.
REQ-035 With IF_JAL_PREDICT_EN, instData=32'h0100006F at PC 32'h20 -> next instReqAddr=32'h30; without the macro -> 32'h24.
REQ-036 rst asserted mid-WAIT with 3 queued entries -> instReq, DecEn and count 0 without a clock edge; a late instRdy is ignored; first post-reset request to RESET_PC.
